// File: rtl/aes_cop_pkg.sv
// Shared definitions for the AES coprocessor stream adapter: register map,
// status commands, adapter FSM states and the config-word selector.
package aes_cop_pkg;

    localparam logic [3:0] ADDR_STATUS = 4'd0;
    localparam logic [3:0] ADDR_NONCE0 = 4'd1;
    localparam logic [3:0] ADDR_KEY0   = 4'd5;
    localparam logic [3:0] ADDR_DIN    = 4'd13;
    localparam logic [3:0] ADDR_DOUT   = 4'd14;

    localparam logic [31:0] STATUS_RUN = 32'h0000_0001;
    localparam logic [31:0] STATUS_RST = 32'h0000_0002;

    localparam int unsigned CFG_WORDS = 12;
    localparam int unsigned BLK_WORDS = 4;

    typedef enum logic [2:0] {IDLE, CFG, LOAD, RUN, WAIT, READ, OUT, ABORT} state_e;

    // Config word idx 0..3 are nonce words, 4..11 are key words.
    function automatic logic [31:0] cfg_word(input logic [255:0] key,
                                             input logic [127:0] nonce,
                                             input logic [3:0]   idx);
        logic [2:0] k;
        k = idx[2:0] - 3'd4;
        if (idx < 4'd4) begin
            cfg_word = nonce[idx[1:0]*32 +: 32];
        end else begin
            cfg_word = key[k*32 +: 32];
        end
    endfunction

endpackage

// File: rtl/aes_cop_word_buf.sv
// 4x32 capture buffer: words are written in order by wr_en_i and read back in
// the same order, advancing the read index on each pop.
module aes_cop_word_buf
    import aes_cop_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        wr_en_i,
    input  logic [31:0] wr_data_i,
    input  logic        pop_i,
    output logic [31:0] rd_data_o,
    output logic        wr_last_o,
    output logic        rd_last_o
);

    logic [31:0] mem_q [BLK_WORDS];
    logic [1:0]  wr_idx_q;
    logic [1:0]  rd_idx_q;

    // Storage and both indices; indices wrap after four words.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(BLK_WORDS); i++) begin
                mem_q[i] <= '0;
            end
            wr_idx_q <= '0;
            rd_idx_q <= '0;
        end else if (clr_i) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_idx_q] <= wr_data_i;
                wr_idx_q        <= wr_idx_q + 2'd1;
            end
            if (pop_i) begin
                rd_idx_q <= rd_idx_q + 2'd1;
            end
        end
    end

    // Read port and last-slot flags.
    always_comb begin
        rd_data_o = mem_q[rd_idx_q];
        wr_last_o = (wr_idx_q == 2'd3);
        rd_last_o = (rd_idx_q == 2'd3);
    end

endmodule

// File: rtl/aes_cop_stream_adapter.sv
// Drives the aes256_coprocessor register bus: one-time key/nonce load, then per
// block 4 words in from a stream, run, wait for interrupt, 4 words back out.
module aes_cop_stream_adapter
    import aes_cop_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic         cfg_start,
    input  logic [255:0] cfg_key,
    input  logic [127:0] cfg_nonce,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [31:0]  s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [31:0]  m_data,
    output logic         busy,
    output logic         err,
    output logic [3:0]   cop_addr,
    output logic [31:0]  cop_din,
    output logic         cop_we,
    input  logic [31:0]  cop_dout,
    input  logic         cop_int
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;     // config word index in CFG, accepted words in LOAD
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            err_q, err_d;

    logic [31:0]     buf_rd;
    logic            buf_wr_last;
    logic            buf_rd_last;

    aes_cop_word_buf u_obuf (
        .clk_i     (clock),
        .rst_ni    (rst_n),
        .clr_i     ((state_q != READ) && (state_q != OUT)),
        .wr_en_i   (state_q == READ),
        .wr_data_i (cop_dout),
        .pop_i     ((state_q == OUT) && m_ready),
        .rd_data_o (buf_rd),
        .wr_last_o (buf_wr_last),
        .rd_last_o (buf_rd_last)
    );

    // State and counter registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    // Next-state and counter updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d = CFG;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            CFG: begin
                if (cnt_q == 4'(CFG_WORDS - 1)) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            LOAD: begin
                if (s_valid) begin
                    if (cnt_q == 4'(BLK_WORDS - 1)) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            RUN: begin
                state_d = WAIT;
                tmo_d   = '0;
            end
            WAIT: begin
                // Interrupt takes priority over a simultaneous timeout.
                if (cop_int) begin
                    state_d = READ;
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ABORT;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            READ: begin
                if (buf_wr_last) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (m_ready && buf_rd_last) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            ABORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus and stream outputs decoded from the current state.
    always_comb begin
        cop_we   = 1'b0;
        cop_addr = ADDR_STATUS;
        cop_din  = '0;
        s_ready  = 1'b0;
        m_valid  = 1'b0;
        m_data   = '0;
        err      = err_q;
        busy     = !((state_q == IDLE) || ((state_q == LOAD) && (cnt_q == 4'd0)));
        unique case (state_q)
            CFG: begin
                cop_we   = 1'b1;
                cop_addr = ADDR_NONCE0 + cnt_q;
                cop_din  = cfg_word(cfg_key, cfg_nonce, cnt_q);
            end
            LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    cop_we   = 1'b1;
                    cop_addr = ADDR_DIN;
                    cop_din  = s_data;
                end
            end
            RUN: begin
                cop_we  = 1'b1;
                cop_din = STATUS_RUN;
            end
            READ: begin
                cop_addr = ADDR_DOUT;
            end
            OUT: begin
                m_valid = 1'b1;
                m_data  = buf_rd;
            end
            ABORT: begin
                cop_we  = 1'b1;
                cop_din = STATUS_RST;
            end
            default: begin
            end
        endcase
    end

endmodule
